axi_stream_remove_header: RTL

AXI_STREAM_REMOVE_HEADER -- requirements
Module: axi_stream_remove_header

---
 rtl/axi_stream_remove_header.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_stream_remove_header.sv
// Strips N = byte_remove_cnt+1 leading bytes from each AXI-Stream packet and realigns the payload.
// Define AXI_STREAM_REMOVE_HEADER_HDR_OUT_EN to present the stripped bytes on the header channel.
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    valid_remove,
  output logic                    ready_remove,
  input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
  output logic                    valid_header,
  input  logic                    ready_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header
);

  localparam int CW = BYTE_CNT_WD + 1;
  localparam logic [CW-1:0] FULL = CW'(DATA_BYTE_WD);

  typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           n_reg;
  logic [CW-1:0]           res_cnt;
  logic [DATA_WD-1:0]      residue;
  logic [CW-1:0]           v_cnt;
  logic [CW-1:0]           rem_cnt;
  logic [CW:0]             sum_cnt;
  logic [DATA_WD-1:0]      din_m;
  logic [DATA_WD-1:0]      body_data;
  logic                    out_free;
  logic                    hdr_free;
  logic                    accept;
  logic                    load_out;
  logic [DATA_WD-1:0]      ld_data;
  logic [DATA_BYTE_WD-1:0] ld_keep;
  logic                    ld_last;

  function automatic logic [CW-1:0] count_ones(input logic [DATA_BYTE_WD-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CW'(k[i]);
    return c;
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] msb_mask(input logic [CW-1:0] n);
    logic [DATA_BYTE_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[DATA_BYTE_WD-1-i] = (i < int'(n));
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] keep_bits(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] b;
    for (int i = 0; i < DATA_BYTE_WD; i++) b[8*i +: 8] = {8{k[i]}};
    return b;
  endfunction

  assign v_cnt     = count_ones(keep_in);
  assign din_m     = data_in & keep_bits(keep_in);
  assign rem_cnt   = (v_cnt > n_reg) ? v_cnt - n_reg : '0;
  assign sum_cnt   = {1'b0, res_cnt} + {1'b0, v_cnt};
  assign body_data = residue | (din_m >> {res_cnt, 3'b000});
  assign out_free  = !valid_out || ready_out;
  assign accept    = valid_in && ready_in;

  // Control FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (valid_remove) state_nxt = FIRST;
      FIRST: if (accept) state_nxt = last_in ? IDLE : BODY;
      BODY:  if (accept && last_in) state_nxt = (sum_cnt > {1'b0, FULL}) ? FLUSH : IDLE;
      FLUSH: if (out_free) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_remove = 1'b0;
    ready_in     = 1'b0;
    case (state)
      IDLE:  ready_remove = 1'b1;
      FIRST: ready_in     = out_free && hdr_free;
      BODY:  ready_in     = out_free;
      default: ;
    endcase
  end

  // Output beat selection for the single register stage
  always_comb begin
    load_out = 1'b0;
    ld_data  = body_data;
    ld_keep  = '1;
    ld_last  = 1'b0;
    case (state)
      FIRST: if (accept && last_in && rem_cnt != '0) begin
        load_out = 1'b1;
        ld_data  = din_m << {n_reg, 3'b000};
        ld_keep  = msb_mask(rem_cnt);
        ld_last  = 1'b1;
      end
      BODY: if (accept) begin
        if (!last_in || sum_cnt > {1'b0, FULL}) begin
          load_out = 1'b1;
        end else if (sum_cnt != '0) begin
          load_out = 1'b1;
          ld_keep  = msb_mask(sum_cnt[CW-1:0]);
          ld_last  = 1'b1;
        end
      end
      FLUSH: if (out_free) begin
        load_out = 1'b1;
        ld_data  = residue;
        ld_keep  = msb_mask(res_cnt);
        ld_last  = 1'b1;
      end
      default: ;
    endcase
  end

  // Residue tracking and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg     <= '0;
      res_cnt   <= '0;
      residue   <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid_remove) n_reg <= {1'b0, byte_remove_cnt} + CW'(1);
        FIRST: if (accept) begin
          residue <= din_m << {n_reg, 3'b000};
          res_cnt <= last_in ? '0 : FULL - n_reg;
        end
        BODY: if (accept) begin
          residue <= din_m << {FULL - res_cnt, 3'b000};
          if (last_in)
            res_cnt <= (sum_cnt > {1'b0, FULL}) ? CW'(sum_cnt - {1'b0, FULL}) : '0;
        end
        FLUSH: if (out_free) begin
          residue <= '0;
          res_cnt <= '0;
        end
        default: ;
      endcase

      if (load_out) begin
        valid_out <= 1'b1;
        data_out  <= ld_data & keep_bits(ld_keep);
        keep_out  <= ld_keep;
        last_out  <= ld_last;
      end else if (valid_out && ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef AXI_STREAM_REMOVE_HEADER_HDR_OUT_EN
  logic [CW-1:0] hdr_cnt;

  function automatic logic [DATA_BYTE_WD-1:0] lsb_mask(input logic [CW-1:0] n);
    logic [DATA_BYTE_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[i] = (i < int'(n));
    return m;
  endfunction

  assign hdr_cnt  = (v_cnt < n_reg) ? v_cnt : n_reg;
  assign hdr_free = !valid_header || ready_header;

  // Header register: stripped bytes right-aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_header <= 1'b0;
      data_header  <= '0;
      keep_header  <= '0;
    end else if (state == FIRST && accept) begin
      valid_header <= 1'b1;
      data_header  <= din_m >> {FULL - hdr_cnt, 3'b000};
      keep_header  <= lsb_mask(hdr_cnt);
    end else if (valid_header && ready_header) begin
      valid_header <= 1'b0;
    end
  end
`else
  // Header bytes are discarded; ready_header has no effect on the stream.
  assign hdr_free     = 1'b1 | ready_header;
  assign valid_header = 1'b0;
  assign data_header  = '0;
  assign keep_header  = '0;
`endif

endmodule
